// File: rtl/seg7_pkg.sv
// Shared types and segment decode for the stopwatch seven-segment display stage.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // gfedcba only; codes 10..15 render as a dash
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  typedef enum logic [1:0] {
    SlotD0,
    SlotD1,
    SlotD2,
    SlotD3
  } slot_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_bcd);
    return SEG_TABLE[i_bcd];
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running modulo-N counter; o_wrap is high during the cycle the count sits at N-1.
module seg7_tick_gen #(
  parameter int unsigned N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = (r_count == W'(N - 1));
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-aligned digit buffering,
// per-slot anti-ghosting guard, blanking and blinking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2000,
  parameter int unsigned BLINK_DIV   = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic        load,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  digit_sel,
  output logic        frame_start
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [RW-1:0] w_ref_cnt;
  logic          w_ref_wrap;
  logic [BW-1:0] w_unused_blink_cnt;
  logic          w_blink_wrap;

  seg7_tick_gen #(.N(REFRESH_DIV)) u_refresh (
    .clk     (clk),
    .rst     (rst),
    .o_count (w_ref_cnt),
    .o_wrap  (w_ref_wrap)
  );

  seg7_tick_gen #(.N(BLINK_DIV)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .o_count (w_unused_blink_cnt),
    .o_wrap  (w_blink_wrap)
  );

  slot_e       r_slot, w_slot_next;
  logic        w_frame_wrap;
  logic        r_blink_phase;
  logic [15:0] r_pend_digits, r_act_digits;
  logic [3:0]  r_pend_dp, r_act_dp;
  logic        r_pend_valid;

  always_comb begin
    w_slot_next = r_slot;
    if (w_ref_wrap) begin
      unique case (r_slot)
        SlotD0:  w_slot_next = SlotD1;
        SlotD1:  w_slot_next = SlotD2;
        SlotD2:  w_slot_next = SlotD3;
        SlotD3:  w_slot_next = SlotD0;
        default: w_slot_next = SlotD0;
      endcase
    end
  end

  assign w_frame_wrap = w_ref_wrap && (r_slot == SlotD3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot        <= SlotD0;
      r_blink_phase <= 1'b0;
    end else begin
      r_slot <= w_slot_next;
      if (w_blink_wrap) r_blink_phase <= ~r_blink_phase;
    end
  end

  // A load coinciding with the frame boundary goes straight to the active copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_valid  <= 1'b0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
    end else if (w_frame_wrap) begin
      if (load) begin
        r_act_digits <= digits_in;
        r_act_dp     <= dp_in;
      end else if (r_pend_valid) begin
        r_act_digits <= r_pend_digits;
        r_act_dp     <= r_pend_dp;
      end
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pend_digits <= digits_in;
      r_pend_dp     <= dp_in;
      r_pend_valid  <= 1'b1;
    end
  end

  logic [1:0] w_idx;
  logic [3:0] w_digit;
  logic       w_lit;
  logic [3:0] w_an_next;
  logic [7:0] w_seg_next;

  always_comb begin
    w_idx      = r_slot;
    w_digit    = r_act_digits[{w_idx, 2'b00} +: 4];
    w_lit      = (w_ref_cnt >= RW'(GUARD)) && !blank_mask[w_idx] &&
                 !(blink_mask[w_idx] && r_blink_phase);
    w_an_next  = 4'hF;
    w_seg_next = SEG_BLANK;
    if (w_lit) begin
      w_an_next  = ~(4'b0001 << w_idx);
      w_seg_next = {~r_act_dp[w_idx], bcd_to_seg(w_digit)};
    end
  end

  logic [3:0] r_an;
  logic [7:0] r_seg;
  logic [1:0] r_digit_sel;
  logic       r_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an          <= 4'hF;
      r_seg         <= SEG_BLANK;
      r_digit_sel   <= 2'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an_next;
      r_seg         <= w_seg_next;
      r_digit_sel   <= w_idx;
      r_frame_start <= w_frame_wrap;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign digit_sel   = r_digit_sel;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed steps plus random loads/masks, checked against a
// cycle-count based reference model of the display timing and buffering rules.
module tb_seg7_scan_driver;

  localparam int unsigned R = 8;
  localparam int unsigned G = 2;
  localparam int unsigned B = 64;
  localparam int unsigned FRAME = 4 * R;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_mask, blink_mask;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  digit_sel;
  logic        frame_start;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(B)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .load        (load),
    .an          (an),
    .seg         (seg),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  // Model state: n = clock edges since reset release
  int unsigned n;
  logic [15:0] m_dig, m_pdig;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pv;
  int          n_asserts = 0;
  int          n_fail = 0;

  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0: c = 8'hC0;
      4'd1: c = 8'hF9;
      4'd2: c = 8'hA4;
      4'd3: c = 8'hB0;
      4'd4: c = 8'h99;
      4'd5: c = 8'h92;
      4'd6: c = 8'h82;
      4'd7: c = 8'hF8;
      4'd8: c = 8'h80;
      4'd9: c = 8'h90;
      default: c = 8'hBF;
    endcase
    return c[6:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (model cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_dig = '0; m_dp = '0; m_pdig = '0; m_pdp = '0; m_pv = 0;
  endtask

  // Predict outputs from the pre-edge state, advance the model, clock, then compare.
  task automatic tick();
    int unsigned slot, cnt;
    bit ph, lit, wrap;
    logic [3:0] ea, d;
    logic [7:0] es;
    slot = (n / R) % 4;
    cnt  = n % R;
    ph   = ((n / B) % 2) == 1;
    lit  = (cnt >= G) && !blank_mask[slot] && !(blink_mask[slot] && ph);
    d    = m_dig[slot*4 +: 4];
    ea   = 4'hF;
    es   = 8'hFF;
    if (lit) begin
      ea[slot] = 1'b0;
      es = {~m_dp[slot], ref_glyph(d)};
    end
    wrap = (cnt == R - 1) && (slot == 3);
    if (wrap) begin
      if (load) begin
        m_dig = digits_in; m_dp = dp_in;
      end else if (m_pv) begin
        m_dig = m_pdig; m_dp = m_pdp;
      end
      m_pv = 0;
    end else if (load) begin
      m_pdig = digits_in; m_pdp = dp_in; m_pv = 1;
    end
    n++;
    @(posedge clk);
    #1;
    check("an", {4'h0, an}, {4'h0, ea});
    check("seg", seg, es);
    check("digit_sel", {6'd0, digit_sel}, 8'(slot));
    check("frame_start", {7'd0, frame_start}, {7'd0, wrap});
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Leaves outputs reflecting slot s, refresh count c.
  task automatic run_to(input int unsigned s, input int unsigned c);
    while (!(((n / R) % 4) == s && (n % R) == c)) tick();
    tick();
  endtask

  task automatic to_frame_start();
    while ((n % FRAME) != 0) tick();
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", {6'd0, digit_sel}, 8'h00);
    check("rst_fs", {7'd0, frame_start}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; digits_in = '0; dp_in = '0; blank_mask = '0; blink_mask = '0; load = 1'b0;
    model_reset();
    #12;
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'hFF);
    check("rst_sel", {6'd0, digit_sel}, 8'h00);
    check("rst_fs", {7'd0, frame_start}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // 1: first load shows from the next frame onward
    load_word(16'h1234, 4'h0);
    to_frame_start();
    run_to(0, 4);
    check("t1_an0", {4'h0, an}, 8'h0E);
    check("t1_seg0", seg, 8'h99);
    run_to(3, 4);
    check("t1_an3", {4'h0, an}, 8'h07);
    check("t1_seg3", seg, 8'hF9);

    // 2: mid-frame load is deferred to the next frame
    to_frame_start();
    run_to(1, 3);
    load_word(16'h5678, 4'h0);
    run_to(3, 5);
    check("t2_old_seg3", seg, 8'hF9);
    to_frame_start();
    run_to(0, 3);
    check("t2_new_seg0", seg, 8'h80);

    // 3: load on the wrap cycle bypasses and discards pending data
    run_to(1, 2);
    load_word(16'h4321, 4'h0);
    while ((n % FRAME) != FRAME - 1) tick();
    load_word(16'h0009, 4'h0);
    run_to(0, 2);
    check("t3_seg0", seg, 8'h90);
    to_frame_start();
    run_to(0, 2);
    check("t3_keep_seg0", seg, 8'h90);

    // 4: blanking and blinking
    blink_mask = 4'b0011;
    blank_mask = 4'b1000;
    run(5 * B / 2);

    // 5: dashes for non-BCD codes, decimal point
    blink_mask = 4'b0000;
    blank_mask = 4'b0000;
    load_word(16'h00FA, 4'b0100);
    to_frame_start();
    run_to(0, 2);
    check("t5_seg0", seg, 8'hBF);
    run_to(1, 2);
    check("t5_seg1", seg, 8'hBF);
    run_to(2, 2);
    check("t5_seg2", seg, 8'h40);

    // 6: reset mid-slot restarts scanning with cleared data
    load_word(16'h8888, 4'hF);
    run_to(2, 4);
    do_reset();
    run_to(0, 2);
    check("t6_an", {4'h0, an}, 8'h0E);
    check("t6_seg", seg, 8'hC0);
    check("t6_sel", {6'd0, digit_sel}, 8'h00);

    // Random loads and mask changes
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        blank_mask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        blink_mask = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) begin
        load_word(16'($urandom), 4'($urandom_range(0, 15)));
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
